// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings and constants for the BIOS/data memory arbiter.
package mem_arb_pkg;

  localparam int MEM_WORD_W = 32;

  // Which port currently wins a simultaneous request.
  typedef enum logic {
    PRI_D = 1'b0,
    PRI_F = 1'b1
  } pri_e;

  // Which port owns the read response arriving next cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_IF   = 2'd1,
    RD_D    = 2'd2
  } rd_owner_e;

endpackage

// File: rtl/mem_arb_starve.sv
// mem_arb_starve: counts consecutive denied fetch cycles and promotes fetch
// to top priority for one grant once the count reaches STARVE_MAX.
// pri_o is the priority state itself, so it doubles as the debug view.
module mem_arb_starve
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic pri_o
);

  localparam logic [3:0] MAX_C = 4'(STARVE_MAX);

  pri_e       pri_q, pri_d;
  logic [3:0] cnt_q, cnt_d;

  // Priority state and starve count registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pri_q <= PRI_D;
      cnt_q <= 4'd0;
    end else begin
      pri_q <= pri_d;
      cnt_q <= cnt_d;
    end
  end

  // Next starve count and priority; fetch is promoted on the edge where the
  // count reaches STARVE_MAX and demoted again after its grant or when idle.
  always_comb begin
    cnt_d = cnt_q;
    pri_d = pri_q;
    if (!if_req_i || if_gnt_i) begin
      cnt_d = 4'd0;
    end else if (cnt_q != MAX_C) begin
      cnt_d = cnt_q + 4'd1;
    end
    case (pri_q)
      PRI_D: if (if_req_i && !if_gnt_i && (cnt_d == MAX_C)) pri_d = PRI_F;
      PRI_F: if (if_gnt_i || !if_req_i) pri_d = PRI_D;
      default: pri_d = PRI_D;
    endcase
  end

  assign pri_o = pri_q;

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous-read memory between the fetch port and
// the load/store port. Load/store wins by default; defining MEM_ARB_STARVE_EN
// adds a starvation guard that periodically lets a blocked fetch through.
//
// Handshake: a requester holds req/addr/data until it sees gnt in the same
// cycle; gnt is combinational and at most one port is granted per cycle. A
// granted read returns data with *_rvalid exactly one cycle later; writes
// produce no rvalid. Requests are never latched here.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW         = 12,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [AW-1:0]         if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [MEM_WORD_W-1:0] if_rdata,
  input  logic                  d_req,
  input  logic [3:0]            d_we,
  input  logic [AW-1:0]         d_addr,
  input  logic [MEM_WORD_W-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [MEM_WORD_W-1:0] d_rdata,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [AW-1:0]         mem_addr,
  output logic [MEM_WORD_W-1:0] mem_din,
  input  logic [MEM_WORD_W-1:0] mem_dout,
  output logic [CNT_W-1:0]      conflicts
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  pri_e                  pri;
  rd_owner_e             rd_owner_q, rd_owner_d;
  logic [CNT_W-1:0]      conflicts_q, conflicts_d;

`ifdef MEM_ARB_STARVE_EN
  logic pri_raw;

  mem_arb_starve #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk_i   (clk),
    .rst_ni  (rst),
    .if_req_i(if_req),
    .if_gnt_i(if_gnt),
    .pri_o   (pri_raw)
  );

  assign pri = pri_e'(pri_raw);
`else
  logic unused_starve_max;

  // Strict load/store priority; the starve threshold has no effect here.
  assign pri               = PRI_D;
  assign unused_starve_max = ^(4'(STARVE_MAX));
`endif

  // Same-cycle grants from requests and priority; both held off in reset.
  always_comb begin
    if_gnt = rst && if_req && ((pri == PRI_F) || !d_req);
    d_gnt  = rst && d_req && ((pri == PRI_D) || !if_req);
  end

  // Memory port mirrors whichever requester is granted.
  always_comb begin
    mem_en   = if_gnt || d_gnt;
    mem_we   = d_gnt ? d_we : 4'b0000;
    mem_addr = d_gnt ? d_addr : if_addr;
    mem_din  = d_wdata;
  end

  // Remember who owns next cycle's read data; saturating conflict count.
  always_comb begin
    rd_owner_d = RD_NONE;
    if (d_gnt && (d_we == 4'b0000)) begin
      rd_owner_d = RD_D;
    end else if (if_gnt) begin
      rd_owner_d = RD_IF;
    end
    conflicts_d = conflicts_q;
    if (if_req && d_req && (conflicts_q != CNT_MAX)) begin
      conflicts_d = conflicts_q + CNT_W'(1);
    end
  end

  // Read-owner and conflict registers; reset drops any read in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_owner_q  <= RD_NONE;
      conflicts_q <= '0;
    end else begin
      rd_owner_q  <= rd_owner_d;
      conflicts_q <= conflicts_d;
    end
  end

  assign if_rvalid = (rd_owner_q == RD_IF);
  assign d_rvalid  = (rd_owner_q == RD_D);
  assign if_rdata  = mem_dout;
  assign d_rdata   = mem_dout;
  assign conflicts = conflicts_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a
// cycle-level reference model (priority rule, memory image, saturating count).
// Build with +define+MEM_ARB_STARVE_EN to cover the starvation guard.
module tb_mem_arbiter;

  localparam int AW         = 12;
  localparam int STARVE_MAX = 4;
  localparam int CNT_W      = 4;
  localparam int W          = 34;
  localparam int CONF_MAX   = (1 << CNT_W) - 1;
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

`ifdef MEM_ARB_STARVE_EN
  localparam bit STARVE_EN = 1'b1;
`else
  localparam bit STARVE_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              d_req;
  logic [3:0]        d_we;
  logic [AW-1:0]     d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;
  logic [CNT_W-1:0]  conflicts;

  mem_arbiter #(
    .AW(AW),
    .STARVE_MAX(STARVE_MAX),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout),
    .conflicts(conflicts)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory macro model ----------------
  logic [31:0] mem_arr [0:4095];
  logic [31:0] ref_mem [0:4095];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) begin
        mem_dout <= mem_arr[mem_addr];
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (mem_we[b]) mem_arr[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        end
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int unsigned  n_tests = 0;
  int unsigned  n_fail  = 0;
  logic [W-1:0] exp_q[$];
  int           m_wait;
  int           m_conf;
  logic         last_if_gnt;
  logic         last_d_gnt;
  logic [31:0]  last_if_rdata;
  logic [31:0]  last_d_rdata;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  task automatic do_cycle(input logic ir, input logic [AW-1:0] ia,
                          input logic dr, input logic [3:0] dwe,
                          input logic [AW-1:0] da, input logic [31:0] dwd);
    logic         promoted;
    logic         e_if;
    logic         e_d;
    logic [W-1:0] e;
    @(negedge clk);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
    #1;
    // response owed by the previous cycle
    e = (exp_q.size() != 0) ? exp_q.pop_front() : {OWN_NONE, 32'h0};
    check_eq("if_rvalid", if_rvalid, e[33:32] == OWN_IF);
    check_eq("d_rvalid", d_rvalid, e[33:32] == OWN_D);
    if (e[33:32] == OWN_IF) check_eq("if_rdata", if_rdata, e[31:0]);
    if (e[33:32] == OWN_D) check_eq("d_rdata", d_rdata, e[31:0]);
    last_if_rdata = if_rdata;
    last_d_rdata  = d_rdata;
    check_eq("conflicts", conflicts, m_conf);
    // fetch wins only when load/store is idle or fetch has waited long enough
    promoted = STARVE_EN && (m_wait >= STARVE_MAX);
    e_if = ir && (!dr || promoted);
    e_d  = dr && !e_if;
    check_eq("if_gnt", if_gnt, e_if);
    check_eq("d_gnt", d_gnt, e_d);
    check_eq("mem_en", mem_en, e_if || e_d);
    if (e_d) begin
      check_eq("mem_addr_d", mem_addr, da);
      check_eq("mem_we_d", mem_we, dwe);
      if (dwe != 4'b0000) check_eq("mem_din", mem_din, dwd);
    end else begin
      check_eq("mem_we_nod", mem_we, 4'b0000);
      if (e_if) check_eq("mem_addr_if", mem_addr, ia);
    end
    last_if_gnt = if_gnt;
    last_d_gnt  = d_gnt;
    // model update for the coming edge
    if (e_d && dwe == 4'b0000) exp_q.push_back({OWN_D, ref_mem[da]});
    else if (e_if) exp_q.push_back({OWN_IF, ref_mem[ia]});
    else exp_q.push_back({OWN_NONE, 32'h0});
    if (e_d && dwe != 4'b0000) begin
      for (int b = 0; b < 4; b++) begin
        if (dwe[b]) ref_mem[da][8*b +: 8] = dwd[8*b +: 8];
      end
    end
    if (ir && !e_if) m_wait = (m_wait < STARVE_MAX) ? m_wait + 1 : STARVE_MAX;
    else m_wait = 0;
    if (ir && dr && m_conf < CONF_MAX) m_conf++;
  endtask

  task automatic idle_cycle;
    do_cycle(1'b0, '0, 1'b0, 4'b0000, '0, 32'h0);
  endtask

  // Assert reset (from the current point), check it, release with idle inputs.
  task automatic apply_reset;
    rst = 1'b0;
    exp_q.delete();
    m_wait = 0;
    m_conf = 0;
    @(negedge clk);
    if_req = 1'b1;
    d_req  = 1'b1;
    d_we   = 4'b0000;
    #1;
    check_eq("rst_if_gnt", if_gnt, 1'b0);
    check_eq("rst_d_gnt", d_gnt, 1'b0);
    check_eq("rst_mem_en", mem_en, 1'b0);
    check_eq("rst_if_rvalid", if_rvalid, 1'b0);
    check_eq("rst_d_rvalid", d_rvalid, 1'b0);
    check_eq("rst_conflicts", conflicts, 0);
    if_req = 1'b0;
    d_req  = 1'b0;
    rst    = 1'b1;
    exp_q.push_back({OWN_NONE, 32'h0});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int          gcount;
    logic [5:0]  gpat;
    logic [31:0] w;
    rst     = 1'b0;
    if_req  = 1'b0;
    if_addr = '0;
    d_req   = 1'b0;
    d_we    = 4'b0000;
    d_addr  = '0;
    d_wdata = 32'h0;
    for (int i = 0; i < 4096; i++) begin
      w = $urandom;
      mem_arr[i] = w;
      ref_mem[i] = w;
    end
    mem_arr[12'h010] = 32'h0000_0013;
    ref_mem[12'h010] = 32'h0000_0013;
    mem_arr[12'h030] = 32'h1122_3344;
    ref_mem[12'h030] = 32'h1122_3344;

    apply_reset();

    // fetch-only read
    do_cycle(1'b1, 12'h010, 1'b0, 4'b0000, '0, 32'h0);
    check_eq("fetch_only_gnt", last_if_gnt, 1'b1);
    idle_cycle();
    check_eq("fetch_only_rdata", last_if_rdata, 32'h0000_0013);

    // simultaneous requests: load wins
    do_cycle(1'b1, 12'h011, 1'b1, 4'b0000, 12'h020, 32'h0);
    check_eq("simul_d_gnt", last_d_gnt, 1'b1);
    idle_cycle();
    check_eq("simul_conflicts", conflicts, 1);

    // partial store then read back
    do_cycle(1'b0, '0, 1'b1, 4'b0011, 12'h030, 32'hDEAD_BEEF);
    idle_cycle();
    do_cycle(1'b0, '0, 1'b1, 4'b0000, 12'h030, 32'h0);
    idle_cycle();
    check_eq("store_readback", last_d_rdata, 32'h1122_BEEF);

`ifdef MEM_ARB_STARVE_EN
    // both requesting: four load grants, one fetch grant, then load again
    gpat = '0;
    for (int i = 0; i < 6; i++) begin
      do_cycle(1'b1, 12'h040 + 12'(i), 1'b1, 4'b0000, 12'h050 + 12'(i), 32'h0);
      gpat[i] = last_if_gnt;
    end
    check_eq("starve_pattern", gpat, 6'b010000);
    idle_cycle();
`else
    gcount = 0;
    for (int i = 0; i < 100; i++) begin
      do_cycle(1'b1, 12'h040, 1'b1, 4'b0000, 12'(i), 32'h0);
      if (last_if_gnt) gcount++;
    end
    check_eq("strict_if_gnt_count", gcount, 0);
    idle_cycle();
`endif

    // reset while a fetch read is in flight
    do_cycle(1'b1, 12'h010, 1'b0, 4'b0000, '0, 32'h0);
    apply_reset();
    do_cycle(1'b1, 12'h012, 1'b1, 4'b0000, 12'h021, 32'h0);
    check_eq("post_rst_d_gnt", last_d_gnt, 1'b1);
    idle_cycle();

    // conflict counter saturation
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, 12'(i), 1'b1, 4'b0000, 12'(i + 100), 32'h0);
    end
    idle_cycle();
    check_eq("conflicts_sat", conflicts, CONF_MAX);

    // randomized traffic over a small address window
    for (int i = 0; i < 400; i++) begin
      do_cycle(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 12'($urandom_range(0, 63)),
               ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
               ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15)),
               12'($urandom_range(0, 63)), $urandom);
    end
    idle_cycle();
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, synchronous-read BIOS/data memory between the CPU's instruction-fetch port and its load/store port. It sits between the pipeline's fetch and memory stages and the memory macro. It issues a same-cycle grant and routes the one-cycle-latency read data back to the owning port. Load/store requests have priority; an optional starvation guard bounds how long fetch can be blocked.

## Interface
Parameters:
- `AW`, 12: word-address width (4096 words).
- `STARVE_MAX`, 4: consecutive denied fetch cycles before fetch is promoted; legal range 1..15.
- `CNT_W`, 16: width of the conflict counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `if_req`  in  1  fetch request.
- `if_addr`  in  AW  fetch word address.
- `if_gnt`  out  1  fetch granted this cycle.
- `if_rvalid`  out  1  fetch read data valid.
- `if_rdata`  out  32  fetch read data.
- `d_req`  in  1  load/store request.
- `d_we`  in  4  byte write mask; 0 means read.
- `d_addr`  in  AW  load/store word address.
- `d_wdata`  in  32  store data.
- `d_gnt`  out  1  load/store granted this cycle.
- `d_rvalid`  out  1  load data valid.
- `d_rdata`  out  32  load data.
- `mem_en`  out  1  memory enable.
- `mem_we`  out  4  memory byte write enable.
- `mem_addr`  out  AW  memory address.
- `mem_din`  out  32  memory write data.
- `mem_dout`  in  32  memory read data; valid the cycle after `mem_en` with `mem_we`==0.
- `conflicts`  out  CNT_W  count of cycles with both requests asserted; saturating.

## Operation
- Priority state `pri`: `PRI_D` (reset) or `PRI_F`.
  - In `PRI_D`: `d_req` wins. Fetch is granted only when `d_req`=0.
  - In `PRI_F`: `if_req` wins. Load/store is granted only when `if_req`=0.
- Grants are combinational from `req` and `pri`. At most one grant per cycle. Both grants are 0 while `rst`=0.
- Memory outputs:
  - With a grant: memory outputs mirror the granted port; `mem_en`=1, and `mem_we`=`d_we` for a load/store grant or 0 for a fetch grant.
  - With no grant: `mem_en`=0 and `mem_we`=0. `mem_addr`/`mem_din` are don't-care.
- Requests are not latched. A requester holds `req`/`addr`/`data` until it sees its `gnt`. Dropping `req` before grant is legal and leaves no state behind.
- Read tracking: registered `rd_owner` ∈ {NONE, IF, D} is set on any read grant.
  - Next cycle, the matching `*_rvalid`=1.
  - Both `*_rdata` are wired to `mem_dout`. Data is meaningful only with `rvalid`.
  - Writes set `rd_owner`=NONE and produce no `rvalid`.
- Back-to-back grants are allowed every cycle. A read response and a new grant overlap freely.
- `conflicts` increments by 1 on each cycle with `if_req`&&`d_req`. It holds at 2^CNT_W−1.

## Timing
- Grant latency: 0 cycles (same cycle as `req`). Read latency: 1 cycle from grant to `rvalid`. Throughput: 1 access per cycle.
- Reset values: `if_rvalid`=0, `d_rvalid`=0, `rd_owner`=NONE, `pri`=PRI_D, starve count=0, `conflicts`=0.
  - Reset is asynchronous. An outstanding read in flight when `rst` falls is discarded; no `rvalid` follows.
- `pri` transitions:
  - PRI_D→PRI_F when the starve count reaches STARVE_MAX at a clock edge.
  - PRI_F→PRI_D on the edge after a fetch grant.
  - PRI_F→PRI_D also when `if_req`=0, so an idle fetch cannot block load/store.
- Starve count (4 bits):
  - Increments on each cycle with `if_req`&&!`if_gnt`.
  - Clears on `if_gnt` or when `if_req`=0.
  - Saturates at STARVE_MAX.

## Configuration
- `MEM_ARB_STARVE_EN` defined: the starve counter and `PRI_F` are compiled in, as described above.
- `MEM_ARB_STARVE_EN` undefined: `pri` is fixed at `PRI_D`, with strict load/store priority and no starve counter. Fetch can be blocked indefinitely by continuous `d_req`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the `pri` encoding (`PRI_D`=0, `PRI_F`=1);
  - the `rd_owner` encoding (NONE=0, IF=1, D=2);
  - the `MEM_WORD_W`=32 constant.
- One sub-module, `mem_arb_starve`, holds the starve counter and the `pri` register. Its inputs are `if_req`/`if_gnt`; its output is `pri`. It is instantiated only under `MEM_ARB_STARVE_EN`.
- The top level holds the grant logic, memory muxing, the `rd_owner` register and the conflict counter.

## Test plan
- Fetch-only read: `if_req`=1, `if_addr`=0x010, memory word 0x00000013 → `if_gnt`=1 same cycle; `if_rvalid`=1 and `if_rdata`=0x00000013 next cycle; `d_rvalid` stays 0.
- Simultaneous requests: `if_req`=`d_req`=1, `d_we`=0, `d_addr`=0x020 → `d_gnt`=1, `if_gnt`=0, `mem_addr`=0x020, `conflicts` 0→1; next cycle `d_rvalid`=1.
- Store: `d_we`=4'b0011, `d_wdata`=0xDEADBEEF, `d_addr`=0x030 → `mem_we`=4'b0011; no `rvalid` the next cycle; a later read of 0x030 returns BEEF in the low half and the prior data in the high half.
- Starvation with `MEM_ARB_STARVE_EN` and STARVE_MAX=4: hold both requests → `d_gnt` for 4 cycles, then `if_gnt`=1 on cycle 5, then `d_gnt` again. Without the macro: `if_gnt` stays 0 for 100 cycles.
- Reset mid-read: grant a fetch read, pull `rst` low before the next edge → `if_rvalid` stays 0 and `conflicts`=0; after release, the first grant behaves as from idle.
- Saturation with CNT_W=4: 20 conflict cycles → `conflicts`=15.
